// File: rtl/uart_pixel_packer_pkg.sv
// Constants and types shared by the UART pixel path and the video timing logic.
package uart_pixel_packer_pkg;
  localparam int H_RES            = 800;
  localparam int V_RES            = 480;
  localparam int FRAME_PIXELS_DEF = H_RES * V_RES;
  localparam int FIFO_W           = 24;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_HI_BYTE   = 2'd1,
    ST_LO_BYTE   = 2'd2
  } state_t;
endpackage

// File: rtl/uart_pixel_packer_idle.sv
// Saturating idle timer; expires one cycle before reaching TIMEOUT_CYCLES unless a byte arrives.
module uart_pixel_packer_idle #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_kick,
  input  logic i_en,
  output logic o_expire
);
  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || i_kick) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TO_W'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Kept independent of i_clr so the FSM can feed its state change back as a clear.
  assign o_expire = i_en && !i_kick && (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/uart_pixel_packer.sv
// Pairs UART bytes into RGB565 pixels for the SDRAM write FIFO, with frame counting and idle resync.
module uart_pixel_packer
  import uart_pixel_packer_pkg::*;
#(
  parameter int FRAME_PIXELS   = FRAME_PIXELS_DEF,
  parameter int CNT_W          = 19,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              init_done,
  input  logic [7:0]        rx_data,
  input  logic              rx_flag,
  output logic              wfifo_wr_en,
  output logic [FIFO_W-1:0] wfifo_wr_data,
  output logic [CNT_W-1:0]  pixel_cnt,
  output logic              frame_done,
  output logic              sync_err
);
  state_t            r_state, w_next_state;
  logic [7:0]        r_hi;
  logic              r_wr_en, r_frame_done, r_sync_err;
  logic [FIFO_W-1:0] r_wr_data;
  logic [CNT_W-1:0]  r_pixel_cnt;

  logic w_expire, w_tmr_clr, w_tmr_en;
  logic w_accept_hi, w_accept_lo, w_expire_lo, w_sync_err, w_cnt_clr, w_last;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) r_state <= ST_WAIT_INIT;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (!init_done) begin
      w_next_state = ST_WAIT_INIT;
    end else begin
      case (r_state)
        ST_WAIT_INIT: w_next_state = ST_HI_BYTE;
        ST_HI_BYTE:   if (rx_flag) w_next_state = ST_LO_BYTE;
        ST_LO_BYTE:   if (rx_flag || w_expire) w_next_state = ST_HI_BYTE;
        default:      w_next_state = ST_WAIT_INIT;
      endcase
    end
  end

  always_comb begin
    w_accept_hi = init_done && (r_state == ST_HI_BYTE) && rx_flag;
    w_accept_lo = init_done && (r_state == ST_LO_BYTE) && rx_flag;
    w_expire_lo = init_done && (r_state == ST_LO_BYTE) && w_expire;
    w_sync_err  = w_expire_lo ||
                  (init_done && (r_state == ST_HI_BYTE) && w_expire && (r_pixel_cnt != '0));
    w_cnt_clr   = !init_done || w_sync_err;
    w_last      = (r_pixel_cnt == CNT_W'(FRAME_PIXELS - 1));
    w_tmr_en    = (r_state != ST_WAIT_INIT);
    w_tmr_clr   = !init_done || (r_state == ST_WAIT_INIT) ||
                  ((w_next_state != r_state) && (w_next_state != ST_WAIT_INIT));
  end

  uart_pixel_packer_idle #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_idle (
    .i_clk   (sclk),
    .i_rst_n (s_rst_n),
    .i_clr   (w_tmr_clr),
    .i_kick  (rx_flag),
    .i_en    (w_tmr_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_hi         <= '0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_pixel_cnt  <= '0;
    end else begin
      r_wr_en      <= w_accept_lo;
      r_frame_done <= w_accept_lo && w_last;
      r_sync_err   <= w_sync_err;
      if (w_accept_hi)                    r_hi <= rx_data;
      else if (w_expire_lo || !init_done) r_hi <= '0;
      if (w_accept_lo) r_wr_data <= {8'h00, r_hi, rx_data};
      if (w_cnt_clr)        r_pixel_cnt <= '0;
      else if (w_accept_lo) r_pixel_cnt <= w_last ? '0 : r_pixel_cnt + 1'b1;
    end
  end

  assign wfifo_wr_en   = r_wr_en;
  assign wfifo_wr_data = r_wr_data;
  assign pixel_cnt     = r_pixel_cnt;
  assign frame_done    = r_frame_done;
  assign sync_err      = r_sync_err;
endmodule
